store_pack: RTL

Store-path narrowing unit: the write-side counterpart of the load/immediate extension logic. It takes a 32-bit register value, byte address and access size from the MEM stage and produces a word-aligned address, lane-replicated write data and byte enables for data memory. It buffers up to two formatted stores behind a valid/ready handshake, and flags misaligned or illegal stores instead of issuing them.

---
 rtl/store_pkg.sv | 15 +
 rtl/store_fmt.sv | 18 +
 rtl/store_pack.sv | 79 +++++++
 3 files changed

// File: rtl/store_pkg.sv
// store_pkg: shared size encodings, byte-enable constants and FIFO entry type
package store_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;
    localparam logic [3:0] BE_ALL  = 4'b1111;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_HI   = 4'b1100;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } entry_t;
endpackage

// File: rtl/store_fmt.sv
// store_fmt: lane replication, byte enables and alignment check for one store
module store_fmt
    import store_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [31:0] data_out,
    output logic [3:0]  be,
    output logic        bad
);
    // replicate the low bits into every lane so memory only needs the enables
    always_comb begin
        data_out = size == SZ_BYTE ? {4{data[7:0]}} : size == SZ_HALF ? {2{data[15:0]}} : data;
        be       = size == SZ_BYTE ? 4'b0001 << addr : size == SZ_HALF ? (addr[1] ? BE_HI : BE_LO) : BE_ALL;
        bad      = size == SZ_ILL || (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr != 2'b00);
    end
endmodule

// File: rtl/store_pack.sv
// store_pack: formats stores and buffers them in a 2-entry FIFO, flagging misaligned ones
module store_pack
    import store_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_size,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic [3:0]  out_be,
    output logic        misalign,
    output logic [31:0] misalign_addr
);
    entry_t      mem_q [DEPTH];
    entry_t      head;
    logic        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        mis_q, mis_d;
    logic [31:0] mis_addr_q, mis_addr_d;
    logic [31:0] fmt_data;
    logic [3:0]  fmt_be;
    logic        fmt_bad, push, pop;

    store_fmt u_fmt (
        .addr     (in_addr[1:0]),
        .size     (in_size),
        .data     (in_data),
        .data_out (fmt_data),
        .be       (fmt_be),
        .bad      (fmt_bad)
    );

    assign in_ready      = count_q < 2'(DEPTH);
    assign out_valid     = count_q != 2'd0;
    assign head          = mem_q[rd_ptr_q];
    assign out_addr      = head.addr;
    assign out_data      = head.data;
    assign out_be        = head.be;
    assign misalign      = mis_q;
    assign misalign_addr = mis_addr_q;

    // rejected stores complete the handshake but only raise the misalign pulse
    always_comb begin
        push       = in_valid && in_ready && !fmt_bad;
        pop        = out_valid && out_ready;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d   = wr_ptr_q ^ push;
        rd_ptr_d   = rd_ptr_q ^ pop;
        mis_d      = in_valid && in_ready && fmt_bad;
        mis_addr_d = mis_d ? in_addr : mis_addr_q;
    end

    // storage is cleared on reset so the idle head presents zeros
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mis_q      <= mis_d;
            mis_addr_q <= mis_addr_d;
            if (push) mem_q[wr_ptr_q] <= '{addr: {in_addr[31:2], 2'b00}, data: fmt_data, be: fmt_be};
        end
    end
endmodule
